// File: rtl/cv32e40p_fpu_lat_tracker.sv
// In-flight tracker for a two-class fixed-latency FPU sharing one writeback port.
// Optional stall performance counter enabled by CV32E40P_FPU_LAT_PERF_EN.
module cv32e40p_fpu_lat_tracker #(
    parameter int ADDMUL_LAT = 2,
    parameter int OTHERS_LAT = 2,
    parameter int MAX_LAT    = 4,
    parameter int TAG_W      = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               issue_valid_i,
    input  logic                               issue_class_i,
    input  logic [TAG_W-1:0]                   issue_tag_i,
    output logic                               issue_ready_o,
    input  logic                               flush_i,
    output logic                               wb_valid_o,
    output logic [TAG_W-1:0]                   wb_tag_o,
    output logic                               wb_class_o,
    output logic                               busy_o,
    output logic [$clog2(2*MAX_LAT+1)-1:0]     inflight_cnt_o
`ifdef CV32E40P_FPU_LAT_PERF_EN
    ,
    output logic [15:0]                        stall_cnt_o
`endif
);

    localparam int CNT_W = $clog2(2*MAX_LAT+1);

    logic             accept;
    logic [1:0]       last_valid;
    logic [TAG_W-1:0] last_tag [2];
    // hold[c]: an op of class c would collide with an offer of the other class
    logic [1:0]       hold;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign issue_ready_o = !hold[~issue_class_i];
    assign accept        = issue_valid_i && issue_ready_o && !flush_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pipe
            localparam int L  = (gi == 0) ? ADDMUL_LAT : OTHERS_LAT;
            localparam int LO = (gi == 0) ? OTHERS_LAT : ADDMUL_LAT;

            logic [L:1]       valid_reg;
            logic [TAG_W-1:0] tag_reg [1:L];
            logic             accept_cls;

            assign accept_cls = accept && (issue_class_i == 1'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= '0;
                    for (int k = 1; k <= L; k++) begin
                        tag_reg[k] <= '0;
                    end
                end else if (flush_i) begin
                    valid_reg <= '0;
                end else begin
                    valid_reg[1] <= accept_cls;
                    tag_reg[1]   <= issue_tag_i;
                    for (int k = 2; k <= L; k++) begin
                        valid_reg[k] <= valid_reg[k-1];
                        tag_reg[k]   <= tag_reg[k-1];
                    end
                end
            end

            assign last_valid[gi] = valid_reg[L];
            assign last_tag[gi]   = tag_reg[L];

            // A longer pipeline blocks the shorter class when their completions would align.
            if (L > LO) begin : g_hold
                assign hold[gi] = valid_reg[L-LO];
            end else begin : g_nohold
                assign hold[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        wb_valid_o = |last_valid;
        wb_tag_o   = '0;
        wb_class_o = 1'b0;
        if (last_valid[1]) begin
            wb_tag_o   = last_tag[1];
            wb_class_o = 1'b1;
        end else if (last_valid[0]) begin
            wb_tag_o   = last_tag[0];
        end
    end

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(accept) - CNT_W'(wb_valid_o);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (flush_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign inflight_cnt_o = cnt_reg;
    assign busy_o         = (cnt_reg != '0);

`ifdef CV32E40P_FPU_LAT_PERF_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (issue_valid_i && !issue_ready_o && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`endif

    a_single_wb : assert property (@(posedge clk) disable iff (rst) !(&last_valid));

endmodule

// File: tb/tb_cv32e40p_fpu_lat_tracker.sv
// Randomized bench for cv32e40p_fpu_lat_tracker (2/4 latency configuration),
// checked against a completion-schedule model keyed by absolute cycle.
module tb_cv32e40p_fpu_lat_tracker;

    localparam int AL    = 2;
    localparam int OL    = 4;
    localparam int ML    = 4;
    localparam int TW    = 6;
    localparam int CNT_W = $clog2(2*ML+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue_valid = 1'b0;
    logic             issue_class = 1'b0;
    logic [TW-1:0]    issue_tag = '0;
    logic             issue_ready;
    logic             flush = 1'b0;
    logic             wb_valid;
    logic [TW-1:0]    wb_tag;
    logic             wb_class;
    logic             busy;
    logic [CNT_W-1:0] inflight_cnt;
`ifdef CV32E40P_FPU_LAT_PERF_EN
    logic [15:0]      stall_cnt;
    int               exp_stall = 0;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    // Model: completion cycle -> tag / class of the op completing then.
    int sched_tag [int];
    int sched_cls [int];

    cv32e40p_fpu_lat_tracker #(
        .ADDMUL_LAT (AL),
        .OTHERS_LAT (OL),
        .MAX_LAT    (ML),
        .TAG_W      (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid_i  (issue_valid),
        .issue_class_i  (issue_class),
        .issue_tag_i    (issue_tag),
        .issue_ready_o  (issue_ready),
        .flush_i        (flush),
        .wb_valid_o     (wb_valid),
        .wb_tag_o       (wb_tag),
        .wb_class_o     (wb_class),
        .busy_o         (busy),
        .inflight_cnt_o (inflight_cnt)
`ifdef CV32E40P_FPU_LAT_PERF_EN
        ,
        .stall_cnt_o    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check_val("rst_ready", int'(issue_ready), 1);
        check_val("rst_wb_valid", int'(wb_valid), 0);
        check_val("rst_wb_tag", int'(wb_tag), 0);
        check_val("rst_wb_class", int'(wb_class), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_inflight", int'(inflight_cnt), 0);
`ifdef CV32E40P_FPU_LAT_PERF_EN
        check_val("rst_stall_cnt", int'(stall_cnt), 0);
`endif
    endtask

    // One cycle: drive after the rising edge, check at the falling edge, update model at the next edge.
    task automatic step(input bit v, input bit c, input int tg, input bit fl);
        bit exp_ready;
        int lc;
        int n;
        issue_valid = v;
        issue_class = c;
        issue_tag   = TW'(tg);
        flush       = fl;
        lc = c ? OL : AL;
        @(negedge clk);
        exp_ready = !sched_tag.exists(cyc + lc);
        n = 0;
        foreach (sched_tag[k]) if (k >= cyc) n++;
        check_val("ready", int'(issue_ready), int'(exp_ready));
        if (sched_tag.exists(cyc)) begin
            check_val("wb_valid", int'(wb_valid), 1);
            check_val("wb_tag", int'(wb_tag), sched_tag[cyc]);
            check_val("wb_class", int'(wb_class), sched_cls[cyc]);
        end else begin
            check_val("wb_valid", int'(wb_valid), 0);
            check_val("wb_tag", int'(wb_tag), 0);
            check_val("wb_class", int'(wb_class), 0);
        end
        check_val("inflight", int'(inflight_cnt), n);
        check_val("busy", int'(busy), int'(n != 0));
`ifdef CV32E40P_FPU_LAT_PERF_EN
        check_val("stall_cnt", int'(stall_cnt), exp_stall);
        if (v && !exp_ready && exp_stall < 65535) exp_stall++;
`endif
        $display("cyc=%0d v=%0d cls=%0d tag=%0d fl=%0d rdy=%0d wb=%0d/%0d/%0d cnt=%0d",
                 cyc, v, c, tg, fl, issue_ready, wb_valid, wb_tag, wb_class, inflight_cnt);
        @(posedge clk);
        if (sched_tag.exists(cyc)) begin
            sched_tag.delete(cyc);
            sched_cls.delete(cyc);
        end
        if (fl) begin
            sched_tag.delete();
            sched_cls.delete();
        end else if (v && exp_ready) begin
            sched_tag[cyc + lc] = tg % (1 << TW);
            sched_cls[cyc + lc] = int'(c);
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic async_reset();
        issue_valid = 1'b0;
        issue_class = 1'b0;
        issue_tag   = '0;
        flush       = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        sched_tag.delete();
        sched_cls.delete();
`ifdef CV32E40P_FPU_LAT_PERF_EN
        exp_stall = 0;
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    initial begin
        #2;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;

        // Back-to-back ADDMUL ops
        step(1, 0, 1, 0); step(1, 0, 2, 0); step(1, 0, 3, 0); idle(4);
        // OTHERS then ADDMUL whose completion would collide: held one cycle
        step(1, 1, 5, 0); idle(1); step(1, 0, 6, 0); step(1, 0, 6, 0); idle(5);
        // ADDMUL then OTHERS: no collision
        step(1, 0, 7, 0); step(1, 1, 8, 0); idle(5);
        // Flush with three ops in flight and a concurrent issue
        step(1, 1, 9, 0); step(1, 0, 10, 0); step(1, 1, 11, 0); step(1, 0, 12, 1); idle(6);
        // Reset mid-stream, then repeat the back-to-back sequence
        step(1, 1, 13, 0); step(1, 0, 14, 0);
        async_reset();
        step(1, 0, 1, 0); step(1, 0, 2, 0); step(1, 0, 3, 0); idle(4);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                async_reset();
            end else begin
                step(bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 1)),
                     int'($urandom_range(0, 63)), bit'($urandom_range(0, 29) == 0));
            end
        end
        idle(6);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/cv32e40p_fpu_lat_tracker.md
Name: cv32e40p_fpu_lat_tracker

Overview:
- Tracks in-flight FP operations for an FPU with one fixed latency per operation class: ADDMUL and OTHERS.
- Latency is generalised from fixed config constants to per-instance parameters.
- Produces writeback-valid/tag timing and blocks issue when two classes would write back in the same cycle on the single FP writeback port.
- Sits between the ID-stage FP issue logic and the EX/WB writeback mux.

Parameters:
- ADDMUL_LAT, 2, latency in cycles of the ADDMUL class; legal range 1..MAX_LAT.
- OTHERS_LAT, 2, latency in cycles of the OTHERS class; legal range 1..MAX_LAT.
- MAX_LAT, 4, upper bound for both latencies; sizes the counter.
- TAG_W, 6, width of the destination-register tag carried with each op.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- issue_valid_i  input  1  FP op offered for issue
- issue_class_i  input  1  0 = ADDMUL, 1 = OTHERS
- issue_tag_i  input  TAG_W  destination tag of the offered op
- issue_ready_o  output  1  op can be accepted this cycle
- flush_i  input  1  kill all in-flight ops
- wb_valid_o  output  1  an op completes this cycle
- wb_tag_o  output  TAG_W  tag of the completing op
- wb_class_o  output  1  class of the completing op
- busy_o  output  1  any op in flight
- inflight_cnt_o  output  $clog2(2*MAX_LAT+1)  number of ops in flight

Behaviour:
- Reset state (async, rst=1): all stages invalid, counter 0. Outputs: wb_valid_o=0, wb_tag_o=0, wb_class_o=0, busy_o=0, inflight_cnt_o=0, issue_ready_o=1.
- Pipelines: one per class, with L = ADDMUL_LAT or OTHERS_LAT.
  - Each pipeline is a valid+tag shift chain, stages 1..L.
  - Stage k holds the op accepted k cycles earlier.
  - The chain advances every cycle, with no backpressure.
- Accept: an op is accepted when issue_valid_i & issue_ready_o & !flush_i. It enters stage 1 of its class at the next edge.
- Writeback: wb_valid_o = stage L valid of either class; wb_tag_o and wb_class_o come from that stage.
  - The outputs are driven combinationally from registers, with no extra register stage.
  - An op accepted at cycle t reports wb_valid_o at cycle t+L.
  - With wb_valid_o=0, wb_tag_o and wb_class_o read as 0.
- Collision rule: let Lc be the offered op's latency and Lo the other class's latency.
  - issue_ready_o=0 when Lo > Lc and stage (Lo-Lc) of the other class is valid.
  - Otherwise issue_ready_o=1.
  - With equal latencies, issue_ready_o is constantly 1.
- Ready dependencies: issue_ready_o may depend on issue_class_i. It must not depend on issue_valid_i.
- Same-cycle writeback by both classes is unreachable. An assertion checks it is never true.
- inflight_cnt_o:
  - +1 on accept, -1 on writeback. Both in one cycle leaves it unchanged.
  - busy_o = (inflight_cnt_o != 0).
- Flush: flush_i=1 clears all stages and the counter at the next edge.
  - An issue offered in the flush cycle is dropped.
  - wb_valid_o in the flush cycle still reflects the op completing that cycle.
- Reset mid-operation: all in-flight state is discarded immediately. No writeback is produced for discarded ops.

Optional Feature:
- Macro: CV32E40P_FPU_LAT_PERF_EN.
- Defined:
  - Adds output stall_cnt_o, 16 bits.
  - Counts cycles where issue_valid_i=1 and issue_ready_o=0.
  - Saturates at 0xFFFF.
  - Reset to 0 by rst.
  - Not cleared by flush_i.
- Undefined: the port and the counter are absent. Core behaviour is identical.

Test Plan:
- Defaults 2/2: ADDMUL tags 1,2,3 issued back-to-back at cycles 0,1,2 -> wb_valid_o at cycles 2,3,4 with tags 1,2,3; issue_ready_o never 0; inflight_cnt_o peaks at 2.
- ADDMUL_LAT=2, OTHERS_LAT=4: OTHERS tag 5 at cycle 0, ADDMUL tag 6 offered at cycle 2 -> issue_ready_o=0 at cycle 2; tag 6 accepted at cycle 3; wb tag 5 at cycle 4 (class 1), wb tag 6 at cycle 5 (class 0).
- Same config: ADDMUL tag 7 at cycle 0, OTHERS tag 8 at cycle 1 -> no stall; wb tag 7 at cycle 2, tag 8 at cycle 5.
- Flush: three ops in flight, flush_i at cycle 1 together with a new issue -> no further wb_valid_o after cycle 1, inflight_cnt_o=0 and busy_o=0 at cycle 2, the new op is never written back.
- Async reset asserted mid-stream -> all outputs return to their reset values immediately; first issue after reset behaves as in scenario 1.
- PERF_EN defined, 2/4 config, scenario 2 stimulus -> stall_cnt_o=1; after 70000 forced stall cycles -> stall_cnt_o=0xFFFF.
